// File: rtl/shift_count_timer_ctrl_pkg.sv
// shift_count_timer_ctrl_pkg: shared state encoding, defaults and counter sizing
package shift_count_timer_ctrl_pkg;
    typedef enum logic [1:0] {SEARCH, SHIFT, COUNT, DONE} state_t;
    localparam int DEF_WIDTH = 4;
    localparam int DEF_PAT_LEN = 4;
    localparam logic [3:0] DEF_PATTERN = 4'b1101;
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/shift_count_timer_ctrl_dp.sv
// shift_count_dp: delay register that loads serially at the LSB and counts down
module shift_count_dp #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_shift_ena,
    input  logic             i_count_ena,
    input  logic             i_din,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_q;
    // shift wins over decrement; the controller never raises both
    always_ff @(posedge clk or posedge rst)
        if (rst) r_q <= '0;
        else if (i_shift_ena) r_q <= {r_q[WIDTH-2:0], i_din};
        else if (i_count_ena) r_q <= r_q - 1'b1;
    assign o_q = r_q;
endmodule

// File: rtl/shift_count_timer_ctrl.sv
// shift_count_timer_ctrl: pattern-triggered serial load followed by a tick-paced countdown
module shift_count_timer_ctrl
    import shift_count_timer_ctrl_pkg::*;
#(
    parameter int                 WIDTH   = DEF_WIDTH,
    parameter int                 TICKS   = 1000,
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data,
    input  logic             ack,
    output logic             shift_ena,
    output logic             count_ena,
    output logic             counting,
    output logic             done,
    output logic [WIDTH-1:0] remaining
);
    localparam int TW = cnt_width(TICKS);
    localparam int SW = cnt_width(WIDTH);
    state_t             r_state, w_next;
    logic [PAT_LEN-1:0] r_hist;
    logic [TW-1:0]      r_tick;
    logic [SW-1:0]      r_scnt;
    logic               w_match, w_tick_end, w_shift_end;
    assign w_match     = {r_hist[PAT_LEN-2:0], data} == PATTERN;
    assign w_tick_end  = r_tick == TW'(TICKS - 1);
    assign w_shift_end = r_scnt == SW'(WIDTH - 1);
    // state register
    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= SEARCH;
        else r_state <= w_next;
    // history only advances while searching and is wiped on leaving DONE so old bits never match
    always_ff @(posedge clk or posedge rst)
        if (rst) r_hist <= '0;
        else r_hist <= (r_state == SEARCH) ? {r_hist[PAT_LEN-2:0], data} : (r_state == DONE && ack) ? '0 : r_hist;
    // shift and tick counters idle at zero outside their states, so each state starts from 0
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_scnt <= '0;
            r_tick <= '0;
        end else begin
            r_scnt <= (r_state == SHIFT && !w_shift_end) ? r_scnt + 1'b1 : '0;
            r_tick <= (r_state == COUNT && !w_tick_end) ? r_tick + 1'b1 : '0;
        end
    // next state and state-decoded outputs
    always_comb begin
        w_next    = r_state;
        count_ena = 1'b0;
        unique case (r_state)
            SEARCH: w_next = w_match ? SHIFT : SEARCH;
            SHIFT:  w_next = w_shift_end ? COUNT : SHIFT;
            COUNT: begin
                count_ena = w_tick_end && remaining != '0;
                w_next    = (w_tick_end && remaining == '0) ? DONE : COUNT;
            end
            DONE:   w_next = ack ? SEARCH : DONE;
        endcase
        shift_ena = r_state == SHIFT;
        counting  = r_state == COUNT;
        done      = r_state == DONE;
    end
    shift_count_dp #(.WIDTH(WIDTH)) u_dp (
        .clk         (clk),
        .rst         (rst),
        .i_shift_ena (shift_ena),
        .i_count_ena (count_ena),
        .i_din       (data),
        .o_q         (remaining)
    );
endmodule

// File: tb/tb_shift_count_timer_ctrl.sv
// tb_shift_count_timer_ctrl: scenario tasks checked against a cycle-level behavioural model
module tb_shift_count_timer_ctrl;
    localparam int TICKS = 4;
    logic clk, rst, data, ack;
    logic shift_ena, count_ena, counting, done;
    logic [3:0] remaining;
    int checks = 0, errors = 0, cyc = 0;
    int n_shift, n_count, n_pulse, n_done;
    string cur_test;
    // model: 0 search, 1 loading, 2 timing, 3 done
    int m_phase, m_rem, m_n, m_delay, m_k;
    bit m_bits[$];

    shift_count_timer_ctrl #(.TICKS(TICKS)) dut (
        .clk(clk), .rst(rst), .data(data), .ack(ack),
        .shift_ena(shift_ena), .count_ena(count_ena), .counting(counting),
        .done(done), .remaining(remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit window_match();
        int w = 0;
        for (int i = 0; i < 4; i++) begin
            int idx = m_bits.size() - 4 + i;
            w = w * 2 + ((idx >= 0) ? int'(m_bits[idx]) : 0);
        end
        return w == 13;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_rem = 0; m_n = 0; m_delay = 0; m_k = 0;
        m_bits.delete();
    endtask

    task automatic clear_stats();
        n_shift = 0; n_count = 0; n_pulse = 0; n_done = 0;
    endtask

    // drive one cycle, compare DUT outputs with model, then advance model at the edge
    task automatic step(input logic d, input logic a);
        logic e_se, e_ce, e_cnt, e_dn;
        logic [3:0] e_rem;
        data = d; ack = a;
        #1;
        e_se  = m_phase == 1;
        e_cnt = m_phase == 2;
        e_dn  = m_phase == 3;
        e_ce  = m_phase == 2 && m_k < m_delay * TICKS && (m_k % TICKS) == TICKS - 1;
        e_rem = (m_phase == 2) ? 4'(m_delay - m_k / TICKS) : 4'(m_rem);
        checks++;
        if ({shift_ena, count_ena, counting, done, remaining} !== {e_se, e_ce, e_cnt, e_dn, e_rem}) begin
            errors++;
            $display("FAIL %s cyc=%0d got se=%b ce=%b cnt=%b dn=%b rem=%0d exp se=%b ce=%b cnt=%b dn=%b rem=%0d",
                     cur_test, cyc, shift_ena, count_ena, counting, done, remaining, e_se, e_ce, e_cnt, e_dn, e_rem);
        end
        n_shift += int'(shift_ena); n_count += int'(counting);
        n_pulse += int'(count_ena); n_done += int'(done);
        @(posedge clk);
        cyc++;
        case (m_phase)
            0: begin
                m_bits.push_back(d);
                if (m_bits.size() > 8) void'(m_bits.pop_front());
                if (window_match()) begin m_phase = 1; m_n = 0; end
            end
            1: begin
                m_rem = ((m_rem << 1) | int'(d)) & 15;
                m_n++;
                if (m_n == 4) begin m_phase = 2; m_delay = m_rem; m_k = 0; end
            end
            2: begin
                m_k++;
                if (m_k == (m_delay + 1) * TICKS) begin m_phase = 3; m_rem = 0; end
            end
            default: if (a) begin m_phase = 0; m_bits.delete(); end
        endcase
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] bits, input int n, input logic a);
        for (int i = n - 1; i >= 0; i--) step(bits[i], a);
    endtask

    task automatic run_until_done(input logic a, input int limit);
        int n = 0;
        while (m_phase != 3 && n < limit) begin
            step(1'($urandom_range(0, 1)), a);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s done_timeout got done=%b exp 1 after %0d cycles", cur_test, done, n);
        end
    endtask

    task automatic test_reset();
        cur_test = "reset";
        rst = 1'b1; data = 1'b0; ack = 1'b0;
        #3;
        checks++;
        if ({shift_ena, count_ena, counting, done, remaining} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 00000000", {shift_ena, count_ena, counting, done, remaining});
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(1'b0, 1'b0);
    endtask

    task automatic test_pattern_load();
        cur_test = "pattern_load";
        send(8'b1101, 4, 1'b0);
        clear_stats();
        send(8'b0101, 4, 1'b0);
        checks++;
        if (remaining !== 4'd5) begin
            errors++; $display("FAIL load_value got %0d exp 5", remaining);
        end
        run_until_done(1'b0, 100);
        checks++;
        if (n_shift != 4 || n_count != 24 || n_pulse != 5) begin
            errors++;
            $display("FAIL load_totals got shift=%0d count=%0d pulse=%0d exp 4 24 5", n_shift, n_count, n_pulse);
        end
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
    endtask

    task automatic test_zero_delay();
        cur_test = "zero_delay";
        send(8'b1101, 4, 1'b0);
        clear_stats();
        send(8'b0000, 4, 1'b0);
        run_until_done(1'b0, 20);
        checks++;
        if (n_count != 4 || n_pulse != 0) begin
            errors++; $display("FAIL zero_totals got count=%0d pulse=%0d exp 4 0", n_count, n_pulse);
        end
        step(1'b0, 1'b1);
    endtask

    task automatic test_overlap_no_reuse();
        cur_test = "overlap";
        send(8'b11101, 5, 1'b0);
        checks++;
        if (shift_ena !== 1'b1) begin
            errors++; $display("FAIL overlap_match got shift_ena=%b exp 1", shift_ena);
        end
        send(8'b0110, 4, 1'b0);
        run_until_done(1'b0, 60);
        step(1'b0, 1'b1);
        clear_stats();
        send(8'b10100, 5, 1'b0);
        checks++;
        if (n_shift != 0) begin
            errors++; $display("FAIL no_reuse got shift cycles=%0d exp 0", n_shift);
        end
        send(8'b1101, 4, 1'b0);
        checks++;
        if (shift_ena !== 1'b1) begin
            errors++; $display("FAIL fresh_match got shift_ena=%b exp 1", shift_ena);
        end
        send(8'b0001, 4, 1'b0);
        run_until_done(1'b0, 20);
        step(1'b0, 1'b1);
    endtask

    task automatic test_ack();
        cur_test = "ack";
        send(8'b1101, 4, 1'b0);
        send(8'b0010, 4, 1'b1);
        run_until_done(1'b1, 40);
        clear_stats();
        for (int i = 0; i < 10; i++) step(1'($urandom_range(0, 1)), 1'b0);
        checks++;
        if (n_done != 10) begin
            errors++; $display("FAIL done_hold got %0d cycles exp 10", n_done);
        end
        step(1'b0, 1'b1);
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL ack_release got done=%b exp 0", done);
        end
        step(1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        int n = 0;
        cur_test = "async_reset";
        send(8'b1101, 4, 1'b0);
        send(8'b0101, 4, 1'b0);
        while (!(m_phase == 2 && m_delay - m_k / TICKS == 3) && n < 50) begin
            step(1'b0, 1'b0);
            n++;
        end
        checks++;
        if (remaining !== 4'd3 || counting !== 1'b1) begin
            errors++; $display("FAIL pre_reset got rem=%0d counting=%b exp 3 1", remaining, counting);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({shift_ena, count_ena, counting, done, remaining} !== 8'h00) begin
            errors++;
            $display("FAIL async_reset got %b exp 00000000", {shift_ena, count_ena, counting, done, remaining});
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        send(8'b1101, 4, 1'b0);
        send(8'b0001, 4, 1'b0);
        run_until_done(1'b0, 20);
        step(1'b0, 1'b1);
    endtask

    task automatic test_max_delay();
        cur_test = "max_delay";
        send(8'b1101, 4, 1'b0);
        clear_stats();
        send(8'b1111, 4, 1'b0);
        checks++;
        if (remaining !== 4'd15) begin
            errors++; $display("FAIL max_load got %0d exp 15", remaining);
        end
        run_until_done(1'b0, 100);
        checks++;
        if (n_count != 64 || n_pulse != 15 || remaining !== 4'd0) begin
            errors++;
            $display("FAIL max_totals got count=%0d pulse=%0d rem=%0d exp 64 15 0", n_count, n_pulse, remaining);
        end
        step(1'b0, 1'b1);
    endtask

    task automatic test_random();
        cur_test = "random";
        for (int i = 0; i < 1500; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
    endtask

    initial begin
        test_reset();
        test_pattern_load();
        test_zero_delay();
        test_overlap_no_reuse();
        test_ack();
        test_async_reset();
        test_max_delay();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
